alu_exec_8bits: RTL
===================

Name: alu_exec_8bits

Overview:
- Execute stage directly downstream of the 8-bit register file.
- Consumes the two read operands (register_data1/register_data2) and a decoded opcode; produces the register file write port (write_enable, write_address, write_data) plus status flags.
- Single-cycle ops are registered with 1-cycle latency.
- MUL is an 8-iteration shift-add FSM that stalls upstream via ready_in.

Parameters:
- DATA_W, 8, operand/result width (only 8 is supported; other values are out of scope).
- ADDR_W, 3, destination register address width (matches the 8-entry register file).

Ports:
- clock_reg  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  decoded instruction present this cycle.
- ready_in  out  1  stage can accept; combinational, 1 when state==IDLE.
- opcode  in  4  operation select, encoding in Behaviour.
- operand_a  in  8  source A (from register_data1).
- operand_b  in  8  source B (from register_data2).
- imm  in  8  immediate value.
- use_imm  in  1  1: imm replaces operand_b.
- dest_addr  in  3  destination register.
- write_enable  out  1  one-cycle write pulse to register file.
- write_address  out  3  registered destination.
- write_data  out  8  registered result.
- flag_zero  out  1  last result == 0.
- flag_carry  out  1  carry/borrow/overflow of last result.
- busy  out  1  1 while MUL is in progress.

Behaviour:
- Reset (asynchronous, any state, including mid-MUL): state=IDLE; write_enable, write_address, write_data, flag_zero, flag_carry, busy all 0; any partial MUL result is discarded; ready_in=1.
- Accept: valid_in & ready_in sampled at a rising edge (edge E0). B = use_imm ? imm : operand_b.
- Opcodes:
  - 0 ADD: 9-bit sum; carry = bit 8.
  - 1 SUB: A-B; carry = borrow (A<B).
  - 2 AND; 3 OR; 4 XOR.
  - 5 NOT: result = ~A.
  - 6 SLL: A<<B[2:0]. 7 SRL: A>>B[2:0] (logical).
  - 8 SLT: result = 1 if A<B unsigned, else 0.
  - 9 MUL: low byte of A*B; carry = 1 if high byte != 0.
  - 10 MOV: result = B.
  - 11-15 NOP: no write; flags unchanged.
- Carry is cleared for opcodes 2-8 and 10.
- Single-cycle ops: at E0, write_data/write_address/flags update and write_enable=1 for exactly the cycle after E0. Latency 1; back-to-back acceptance every cycle is allowed.
- write_enable is suppressed (0) when dest_addr==0, because register 0 is hardwired zero. Flags and write_data still update.
- No accept (valid_in=0 or ready_in=0) at an edge: write_enable=0 next cycle; write_data, write_address and flags hold.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - E0: latch A, B, dest into internal regs; acc=0; cnt=0; state=MUL; busy=1; write_enable=0.
  - Edges E1..E8: if B_shift[0] then acc += A_shift (16-bit); A_shift<<=1; B_shift>>=1; cnt++.
  - At E8 (cnt==7 being processed): outputs load acc[7:0]; carry = |acc[15:8]; zero per result; write_enable=1 for the next cycle (subject to the dest==0 rule); state=IDLE; busy=0.
  - ready_in=0 from after E0 through E8. A new instruction can be accepted at E9.
- valid_in during MUL: ignored. Upstream must hold the instruction until ready_in=1.
- Inputs other than valid_in are don't-care when valid_in=0.

Optional Feature:
- ALU_MUL_EN:
  - Defined: MUL FSM present as above.
  - Undefined: opcode 9 is treated as NOP, no FSM is built, ready_in is constant 1, and busy is constant 0.

Test Plan:
- Reset mid-op: accept MUL 0x0F*0x11, assert reset low at E4 -> all outputs 0, busy=0, ready_in=1; no write_enable pulse after release.
- ADD carry: A=0xF0, B=0x20, dest=3 -> next cycle write_enable=1, write_address=3, write_data=0x10, carry=1, zero=0.
- SUB zero/borrow: A=0x05, imm=0x05 with use_imm=1 -> data 0x00, zero=1, carry=0. Then A=0x03, B=0x04 -> data 0xFF, carry=1.
- Dest 0: XOR A=0xAA, B=0x55, dest=0 -> write_enable stays 0; write_data=0xFF; zero=0.
- MUL: 0x0F*0x11, dest=5 -> ready_in low 8 cycles; write_data=0xFF, carry=0 one cycle after E8. Then 0x20*0x10 -> data 0x00, carry=1, zero=1.
- Back-to-back and stall:
  - ADD, SLL (0x81<<1 -> 0x02), NOP on consecutive cycles -> write_enable 1,1,0; flags unchanged on the NOP.
  - valid_in held high during MUL -> only one write occurs.

Source files
------------

// File: rtl/alu_exec_8bits.sv
// alu_exec_8bits: 8-bit execute stage feeding the register file write port.
// Single-cycle ALU ops register in one cycle; MUL is an 8-step shift-add FSM.
// Optional macro ALU_MUL_EN builds the MUL FSM; undefined, opcode 9 is a NOP.
// Ports: clock_reg, reset (async, active-low), valid_in/ready_in handshake,
//   opcode, operand_a, operand_b, imm, use_imm, dest_addr in;
//   write_enable, write_address, write_data, flag_zero, flag_carry, busy out.
module alu_exec_8bits #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;

    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [2:0]        shamt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_wr;
    logic              accept;

    // Results coming out of the multiplier when it finishes.
    logic              mul_done;
    logic [DATA_W-1:0] mul_res;
    logic              mul_carry;
    logic [ADDR_W-1:0] mul_dest;

    assign accept = valid_in & ready_in;

    always_comb begin
        opb       = use_imm ? imm : operand_b;
        sum       = {1'b0, operand_a} + {1'b0, opb};
        // Top bit of the widened difference is the borrow (A < B unsigned).
        diff      = {1'b0, operand_a} - {1'b0, opb};
        shamt     = opb[2:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_wr    = 1'b1;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];
            end
            OP_AND: alu_res = operand_a & opb;
            OP_OR:  alu_res = operand_a | opb;
            OP_XOR: alu_res = operand_a ^ opb;
            OP_NOT: alu_res = ~operand_a;
            OP_SLL: alu_res = operand_a << shamt;
            OP_SRL: alu_res = operand_a >> shamt;
            OP_SLT: alu_res = DATA_W'(diff[DATA_W]);
            OP_MOV: alu_res = opb;
            // MUL is handled by the FSM (or is a NOP without it).
            OP_MUL: alu_wr = 1'b0;
            default: alu_wr = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t              state;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] a_sh;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0]   b_sh;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   m_dest;

    assign ready_in  = (state == S_IDLE);
    assign acc_nxt   = acc + (b_sh[0] ? a_sh : '0);
    assign mul_done  = (state == S_MUL) && (cnt == CNT_W'(DATA_W - 1));
    assign mul_res   = acc_nxt[DATA_W-1:0];
    assign mul_carry = |acc_nxt[2*DATA_W-1:DATA_W];
    assign mul_dest  = m_dest;

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            m_dest <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && opcode == OP_MUL) begin
                        acc    <= '0;
                        a_sh   <= {{DATA_W{1'b0}}, operand_a};
                        b_sh   <= opb;
                        cnt    <= '0;
                        m_dest <= dest_addr;
                        busy   <= 1'b1;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (mul_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign ready_in  = 1'b1;
    assign busy      = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_carry = 1'b0;
    assign mul_dest  = '0;
`endif

    // Write port and flags; register 0 is hardwired zero so never written.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (mul_done) begin
                write_enable  <= (mul_dest != '0);
                write_address <= mul_dest;
                write_data    <= mul_res;
                flag_zero     <= (mul_res == '0);
                flag_carry    <= mul_carry;
            end else if (accept && alu_wr) begin
                write_enable  <= (dest_addr != '0);
                write_address <= dest_addr;
                write_data    <= alu_res;
                flag_zero     <= (alu_res == '0);
                flag_carry    <= alu_carry;
            end
        end
    end

endmodule
